// File: rtl/tic_toc_turn_ctrl.sv
// Turn sequencer for a tic-tac-toe datapath: takes player/computer move requests,
// strobes them into the board, and tracks turn, move count, the turn timer and game end.
module tic_toc_turn_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit FIRST_MOVER    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       player_req,
  input  logic [3:0] player_pos,
  input  logic       comp_req,
  input  logic [3:0] comp_pos,
  input  logic       invalid_move,
  input  logic [1:0] winner,
  output logic [3:0] player,
  output logic [3:0] computer,
  output logic       plyr_play,
  output logic       comp_play,
  output logic       board_clr,
  output logic       turn,
  output logic       move_ack,
  output logic       move_nack,
  output logic       timeout,
  output logic [3:0] move_count,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    WAIT   = 3'd2,
    APPLY  = 3'd3,
    SETTLE = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] MAX_MOVES  = 4'd9;
  localparam logic [1:0] CONTINUING = 2'd3;

  state_t     state_reg, state_next;
  logic       turn_reg, turn_next;
  logic [7:0] timer_reg, timer_next;
  logic [3:0] count_reg, count_next;
  logic [3:0] player_reg, player_next;
  logic [3:0] computer_reg, computer_next;
  logic       ack_reg, ack_next;
  logic       nack_reg, nack_next;
  logic       req_sel;
  logic [3:0] pos_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      turn_reg     <= FIRST_MOVER;
      timer_reg    <= 8'd0;
      count_reg    <= 4'd0;
      player_reg   <= 4'd0;
      computer_reg <= 4'd0;
      ack_reg      <= 1'b0;
      nack_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      turn_reg     <= turn_next;
      timer_reg    <= timer_next;
      count_reg    <= count_next;
      player_reg   <= player_next;
      computer_reg <= computer_next;
      ack_reg      <= ack_next;
      nack_reg     <= nack_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    turn_next     = turn_reg;
    timer_next    = timer_reg;
    count_next    = count_reg;
    player_next   = player_reg;
    computer_next = computer_reg;
    ack_next      = 1'b0;
    nack_next     = 1'b0;
    timeout       = 1'b0;
    // Only the side whose turn it is gets looked at.
    req_sel       = turn_reg ? comp_req : player_req;
    pos_sel       = turn_reg ? comp_pos : player_pos;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLR;
          count_next = 4'd0;
          turn_next  = FIRST_MOVER;
          timer_next = 8'd0;
        end
      end
      CLR: begin
        count_next = 4'd0;
        turn_next  = FIRST_MOVER;
        timer_next = 8'd0;
        state_next = WAIT;
      end
      WAIT: begin
        if (req_sel && (pos_sel <= 4'd8)) begin
          if (turn_reg) computer_next = pos_sel;
          else          player_next   = pos_sel;
          state_next = APPLY;
        end else begin
          // An out-of-range slot is rejected but still lets the clock run.
          nack_next = req_sel;
          if (timer_reg == TIMER_LAST) begin
            timeout    = 1'b1;
            turn_next  = ~turn_reg;
            timer_next = 8'd0;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
      end
      APPLY: begin
        if (invalid_move) begin
          nack_next  = 1'b1;
          timer_next = 8'd0;
          state_next = WAIT;
        end else begin
          ack_next   = 1'b1;
          count_next = (count_reg == MAX_MOVES) ? MAX_MOVES : count_reg + 4'd1;
          state_next = SETTLE;
        end
      end
      SETTLE: state_next = CHECK;
      CHECK: begin
        if ((winner != CONTINUING) || (count_reg == MAX_MOVES)) begin
          state_next = DONE;
        end else begin
          turn_next  = ~turn_reg;
          timer_next = 8'd0;
          state_next = WAIT;
        end
      end
      DONE: begin
        if (start) begin
          state_next = CLR;
          count_next = 4'd0;
          turn_next  = FIRST_MOVER;
          timer_next = 8'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign player     = player_reg;
  assign computer   = computer_reg;
  assign plyr_play  = (state_reg == APPLY) && !turn_reg;
  assign comp_play  = (state_reg == APPLY) && turn_reg;
  assign board_clr  = (state_reg == CLR);
  assign turn       = turn_reg;
  assign move_ack   = ack_reg;
  assign move_nack  = nack_reg;
  assign move_count = count_reg;
  assign game_over  = (state_reg == DONE);

endmodule

// File: tb/tb_tic_toc_turn_ctrl.sv
// Directed bench for tic_toc_turn_ctrl: moves, rejects, timeout, game end and async reset.
module tb_tic_toc_turn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       player_req;
  logic [3:0] player_pos;
  logic       comp_req;
  logic [3:0] comp_pos;
  logic       invalid_move;
  logic [1:0] winner;
  logic [3:0] player;
  logic [3:0] computer;
  logic       plyr_play;
  logic       comp_play;
  logic       board_clr;
  logic       turn;
  logic       move_ack;
  logic       move_nack;
  logic       timeout;
  logic [3:0] move_count;
  logic       game_over;

  int tests_run = 0;
  int tests_failed = 0;

  tic_toc_turn_ctrl #(.TIMEOUT_CYCLES(3), .FIRST_MOVER(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .player_req   (player_req),
    .player_pos   (player_pos),
    .comp_req     (comp_req),
    .comp_pos     (comp_pos),
    .invalid_move (invalid_move),
    .winner       (winner),
    .player       (player),
    .computer     (computer),
    .plyr_play    (plyr_play),
    .comp_play    (comp_play),
    .board_clr    (board_clr),
    .turn         (turn),
    .move_ack     (move_ack),
    .move_nack    (move_nack),
    .timeout      (timeout),
    .move_count   (move_count),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in a WAIT cycle whose turn is 'side'; ends one cycle after CHECK.
  task automatic do_move(input logic side, input logic [3:0] pos, input logic [1:0] win,
                         input logic [3:0] exp_cnt);
    check("turn_before", turn, side);
    if (side) begin comp_req = 1'b1; comp_pos = pos; end
    else      begin player_req = 1'b1; player_pos = pos; end
    #1;
    check("no_timeout", timeout, 1'b0);
    step();
    player_req = 1'b0;
    comp_req   = 1'b0;
    check("play", side ? comp_play : plyr_play, 1'b1);
    check("other_play", side ? plyr_play : comp_play, 1'b0);
    check("slot", side ? computer : player, pos);
    invalid_move = 1'b0;
    step();
    check("ack", move_ack, 1'b1);
    check("count", move_count, exp_cnt);
    winner = win;
    step();
    check("ack_1cyc", move_ack, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; player_req = 1'b0; player_pos = 4'd0;
    comp_req = 1'b0; comp_pos = 4'd0; invalid_move = 1'b0; winner = 2'd3;
    repeat (2) @(negedge clk);
    check("rst_player", player, 4'd0);
    check("rst_computer", computer, 4'd0);
    check("rst_turn", turn, 1'b0);
    check("rst_count", move_count, 4'd0);
    check("rst_game_over", game_over, 1'b0);
    check("rst_board_clr", board_clr, 1'b0);
    reset = 1'b1;
    step(); step();
    check("idle_no_clr", board_clr, 1'b0);
    check("idle_no_play", plyr_play, 1'b0);

    // First move: player takes centre; a simultaneous computer request is ignored.
    start = 1'b1;
    step();
    check("clr_pulse", board_clr, 1'b1);
    start = 1'b0;
    step();
    check("clr_1cyc", board_clr, 1'b0);
    check("first_turn", turn, 1'b0);
    player_req = 1'b1; player_pos = 4'd4; comp_req = 1'b1; comp_pos = 4'd7;
    step();
    player_req = 1'b0; comp_req = 1'b0;
    check("p4_play", plyr_play, 1'b1);
    check("p4_comp_play", comp_play, 1'b0);
    check("p4_slot", player, 4'd4);
    check("p4_comp_hold", computer, 4'd0);
    step();
    check("p4_ack", move_ack, 1'b1);
    check("p4_play_1cyc", plyr_play, 1'b0);
    check("p4_count", move_count, 4'd1);
    step(); step();
    check("p4_turn", turn, 1'b1);

    // Computer tries the occupied slot.
    comp_req = 1'b1; comp_pos = 4'd4;
    step();
    comp_req = 1'b0;
    check("c4_play", comp_play, 1'b1);
    check("c4_slot", computer, 4'd4);
    check("c4_player_hold", player, 4'd4);
    invalid_move = 1'b1;
    step();
    invalid_move = 1'b0;
    check("c4_nack", move_nack, 1'b1);
    check("c4_no_ack", move_ack, 1'b0);
    check("c4_turn", turn, 1'b1);
    check("c4_count", move_count, 4'd1);

    // Idle for three WAIT cycles: forfeit on the third.
    check("to_w1", timeout, 1'b0);
    step();
    check("to_w2", timeout, 1'b0);
    step();
    check("to_w3", timeout, 1'b1);
    check("to_w3_turn", turn, 1'b1);
    step();
    check("to_after", timeout, 1'b0);
    check("to_turn", turn, 1'b0);
    check("to_count", move_count, 4'd1);

    // Out-of-range slot: rejected, no strobe, timer keeps running.
    player_req = 1'b1; player_pos = 4'd9;
    step();
    player_req = 1'b0;
    check("p9_nack", move_nack, 1'b1);
    check("p9_no_play", plyr_play, 1'b0);
    step();
    check("p9_still_wait", plyr_play, 1'b0);
    check("p9_nack_1cyc", move_nack, 1'b0);

    // Valid request on the expiry cycle wins, then play out a player win.
    do_move(1'b0, 4'd0, 2'd3, 4'd2);
    do_move(1'b1, 4'd3, 2'd3, 4'd3);
    do_move(1'b0, 4'd1, 2'd3, 4'd4);
    do_move(1'b1, 4'd5, 2'd3, 4'd5);
    check("pre_win_go", game_over, 1'b0);
    do_move(1'b0, 4'd2, 2'd1, 4'd6);
    check("win_game_over", game_over, 1'b1);
    player_req = 1'b1; player_pos = 4'd6; comp_req = 1'b1; comp_pos = 4'd7;
    step(); step();
    player_req = 1'b0; comp_req = 1'b0;
    check("done_no_pplay", plyr_play, 1'b0);
    check("done_no_cplay", comp_play, 1'b0);
    check("done_no_ack", move_ack, 1'b0);
    check("done_player_hold", player, 4'd2);
    check("done_level", game_over, 1'b1);

    // Restart from DONE.
    start = 1'b1; winner = 2'd3;
    step();
    start = 1'b0;
    check("re_clr", board_clr, 1'b1);
    check("re_count", move_count, 4'd0);
    check("re_go", game_over, 1'b0);
    step();
    do_move(1'b0, 4'd4, 2'd3, 4'd1);

    // Async reset in the middle of a computer APPLY.
    comp_req = 1'b1; comp_pos = 4'd8;
    step();
    comp_req = 1'b0;
    check("rstm_play", comp_play, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rstm_comp_play", comp_play, 1'b0);
    check("rstm_computer", computer, 4'd0);
    check("rstm_player", player, 4'd0);
    check("rstm_count", move_count, 4'd0);
    check("rstm_turn", turn, 1'b0);
    @(negedge clk);
    step();
    check("rstm_no_ack", move_ack, 1'b0);
    reset = 1'b1;
    step();
    check("rstm_idle_ack", move_ack, 1'b0);
    check("rstm_idle_clr", board_clr, 1'b0);

    // Full draw: nine moves end the game on count.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      do_move(i[0], 4'(i), 2'd3, 4'(i + 1));
    end
    check("draw_game_over", game_over, 1'b1);
    check("draw_count", move_count, 4'd9);
    check("draw_turn", turn, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
